pulse_burst_monitor: RTL and testbench

Downstream consumer of the trigger-started divided-pulse counter's `out_pulse`. Measures each burst of high pulses (count, min/max high width, optional width check) and delivers one result record per burst over a valid/ready handshake. Used in bring-up and self-check paths to confirm pulse-generator programming without a logic analyser.

---
 rtl/pulse_burst_monitor_pkg.sv | 18 +
 rtl/pulse_burst_monitor_if.sv | 15 +
 rtl/pulse_burst_monitor_sat_cnt.sv | 20 ++
 rtl/pulse_burst_monitor.sv | 136 +++++++++++++
 tb/tb_pulse_burst_monitor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pulse_burst_monitor_pkg.sv
// pulse_mon_pkg: shared state enum, result record and field widths for pulse_burst_monitor.
// Field widths follow the default MAX_PULSES/MAX_WIDTH; instances must not exceed them.
package pulse_mon_pkg;
   localparam int MAX_PULSES_DEF = 16;
   localparam int MAX_WIDTH_DEF  = 64;
   localparam int CNT_W = $clog2(MAX_PULSES_DEF + 1);
   localparam int WID_W = $clog2(MAX_WIDTH_DEF + 1);

   typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [WID_W-1:0] min_w;
      logic [WID_W-1:0] max_w;
      logic             ovf;
      logic             width_err;
   } result_t;
endpackage

// File: rtl/pulse_burst_monitor_if.sv
// pulse_burst_monitor_if: valid/ready result channel carrying one burst record.
interface pulse_burst_monitor_if;
   import pulse_mon_pkg::*;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_count;
   logic [WID_W-1:0] res_min_w;
   logic [WID_W-1:0] res_max_w;
   logic             res_ovf;
   logic             res_width_err;
   modport master (output res_valid, res_count, res_min_w, res_max_w, res_ovf, res_width_err,
                   input  res_ready);
   modport slave  (input  res_valid, res_count, res_min_w, res_max_w, res_ovf, res_width_err,
                   output res_ready);
endinterface

// File: rtl/pulse_burst_monitor_sat_cnt.sv
// sat_cnt: up-counter that holds at MAX; sync clear beats load beats increment.
module sat_cnt #(
   parameter int         W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d;
   always_comb q_d = clr ? '0 : ld ? ld_val : (inc && q_q != MAX) ? q_q + 1'b1 : q_q;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) q_q <= '0;
      else       q_q <= q_d;
   assign q = q_q;
endmodule

// File: rtl/pulse_burst_monitor.sv
// pulse_burst_monitor: measures bursts of high pulses and emits one record per burst.
// Optional PULSE_MON_WIDTH_CHECK_EN flags any closed pulse whose width differs from EXP_WIDTH.
module pulse_burst_monitor
   import pulse_mon_pkg::*;
#(
   parameter int MAX_PULSES = MAX_PULSES_DEF,
   parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
   parameter int GAP_CYCLES = 8,
   parameter int EXP_WIDTH  = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        clr,
   input  logic                        pulse_in,
   pulse_burst_monitor_if.master       res,
   output logic [7:0]                  drop_cnt
);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WID_W-1:0] min_q, min_d, max_q, max_d;
   logic             ovf_q, ovf_d, werr_q, werr_d;
   result_t          res_q, res_d;
   logic             valid_q, valid_d;
   logic [WID_W-1:0] w_cnt;
   logic [GW-1:0]    g_cnt;
   logic             w_ld, w_inc, g_ld, g_inc, done, load, drop_inc, w_bad, w_sat, c_sat;

   sat_cnt #(.W(WID_W), .MAX(WID_W'(MAX_WIDTH))) u_w_cnt (
      .clk(clk), .rstn(rstn), .clr(clr), .ld(w_ld), .ld_val(WID_W'(1)), .inc(w_inc), .q(w_cnt));
   sat_cnt #(.W(GW), .MAX(GW'(GAP_CYCLES))) u_g_cnt (
      .clk(clk), .rstn(rstn), .clr(clr), .ld(g_ld), .ld_val(GW'(1)), .inc(g_inc), .q(g_cnt));
   sat_cnt #(.W(8), .MAX(8'hFF)) u_drop_cnt (
      .clk(clk), .rstn(rstn), .clr(clr), .ld(1'b0), .ld_val(8'h00), .inc(drop_inc), .q(drop_cnt));

   assign w_sat = w_cnt == WID_W'(MAX_WIDTH);
   assign c_sat = count_q == CNT_W'(MAX_PULSES);

`ifdef PULSE_MON_WIDTH_CHECK_EN
   assign w_bad = w_cnt != WID_W'(EXP_WIDTH);
`else
   // Constant false: no compare hardware, EXP_WIDTH merely stays referenced.
   assign w_bad = EXP_WIDTH < 0;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      min_d   = min_q;
      max_d   = max_q;
      ovf_d   = ovf_q;
      werr_d  = werr_q;
      w_ld    = 1'b0;
      w_inc   = 1'b0;
      g_ld    = 1'b0;
      g_inc   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (pulse_in) begin
            state_d = HIGH;
            w_ld    = 1'b1;
            count_d = '0;
            min_d   = '1;
            max_d   = '0;
            ovf_d   = 1'b0;
            werr_d  = 1'b0;
         end
         HIGH: if (pulse_in) begin
            w_inc = 1'b1;
            ovf_d = ovf_q | w_sat;
         end else begin
            state_d = GAP;
            g_ld    = 1'b1;
            count_d = c_sat ? count_q : count_q + 1'b1;
            ovf_d   = ovf_q | c_sat;
            min_d   = w_cnt < min_q ? w_cnt : min_q;
            max_d   = w_cnt > max_q ? w_cnt : max_q;
            werr_d  = werr_q | w_bad;
         end
         GAP: if (pulse_in) begin
            state_d = HIGH;
            w_ld    = 1'b1;
         end else if (g_cnt == GW'(GAP_CYCLES - 1)) begin
            state_d = IDLE;
            done    = 1'b1;
         end else begin
            g_inc = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // A pending record is only replaced when it is being handed off this very cycle.
      load     = done && (!valid_q || res.res_ready);
      drop_inc = done && valid_q && !res.res_ready;
      res_d    = load ? '{count: count_q, min_w: min_q, max_w: max_q, ovf: ovf_q, width_err: werr_q} : res_q;
      valid_d  = load | (valid_q & ~res.res_ready);
      if (clr) begin
         state_d = IDLE;
         count_d = '0;
         min_d   = '1;
         max_d   = '0;
         ovf_d   = 1'b0;
         werr_d  = 1'b0;
         res_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q <= IDLE;
         count_q <= '0;
         min_q   <= '1;
         max_q   <= '0;
         ovf_q   <= 1'b0;
         werr_q  <= 1'b0;
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         min_q   <= min_d;
         max_q   <= max_d;
         ovf_q   <= ovf_d;
         werr_q  <= werr_d;
         res_q   <= res_d;
         valid_q <= valid_d;
      end

   assign res.res_valid     = valid_q;
   assign res.res_count     = res_q.count;
   assign res.res_min_w     = res_q.min_w;
   assign res.res_max_w     = res_q.max_w;
   assign res.res_ovf       = res_q.ovf;
   assign res.res_width_err = res_q.width_err;
endmodule

// File: tb/tb_pulse_burst_monitor.sv
// tb_pulse_burst_monitor: directed table of bursts plus hand-written corner sequences.
module tb_pulse_burst_monitor;
   localparam int GAP = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       clr = 1'b0;
   logic       pulse_in = 1'b0;
   logic [7:0] drop_cnt;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      int n;
      int w;
      int low;
      int c;
      int mn;
      int mx;
      int ovf;
   } vec_t;
   vec_t tbl[6];

   pulse_burst_monitor_if rif();

   pulse_burst_monitor dut (
      .clk(clk), .rstn(rstn), .clr(clr), .pulse_in(pulse_in), .res(rif), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic int werr_exp(input int bad);
`ifdef PULSE_MON_WIDTH_CHECK_EN
      return bad;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic lvl);
      pulse_in = lvl;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lvl, input int n);
      repeat (n) step(lvl);
   endtask

   // Drives all pulses and stops one low short of completing the burst.
   task automatic burst(input int n, input int w, input int low);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, w);
         drive(1'b0, (i < n - 1) ? low : GAP - 1);
      end
   endtask

   task automatic expect_rec(input string nm, input int c, input int mn, input int mx,
                             input int ov, input int we);
      check({nm, ".valid"}, int'(rif.res_valid), 1);
      check({nm, ".count"}, int'(rif.res_count), c);
      check({nm, ".min"},   int'(rif.res_min_w), mn);
      check({nm, ".max"},   int'(rif.res_max_w), mx);
      check({nm, ".ovf"},   int'(rif.res_ovf), ov);
      check({nm, ".werr"},  int'(rif.res_width_err), we);
   endtask

   task automatic expect_zero(input string nm);
      check({nm, ".valid"}, int'(rif.res_valid), 0);
      check({nm, ".count"}, int'(rif.res_count), 0);
      check({nm, ".min"},   int'(rif.res_min_w), 0);
      check({nm, ".max"},   int'(rif.res_max_w), 0);
      check({nm, ".ovf"},   int'(rif.res_ovf), 0);
      check({nm, ".werr"},  int'(rif.res_width_err), 0);
      check({nm, ".drop"},  int'(drop_cnt), 0);
   endtask

   task automatic accept(input string nm);
      rif.res_ready = 1'b1;
      step(1'b0);
      rif.res_ready = 1'b0;
      check({nm, ".accepted"}, int'(rif.res_valid), 0);
   endtask

   initial begin
      rif.res_ready = 1'b0;
      tbl[0] = '{n: 2,  w: 4,  low: 4, c: 2,  mn: 4,  mx: 4,  ovf: 0};
      tbl[1] = '{n: 18, w: 1,  low: 1, c: 16, mn: 1,  mx: 1,  ovf: 1};
      tbl[2] = '{n: 1,  w: 70, low: 1, c: 1,  mn: 64, mx: 64, ovf: 1};
      tbl[3] = '{n: 3,  w: 1,  low: 7, c: 3,  mn: 1,  mx: 1,  ovf: 0};
      tbl[4] = '{n: 16, w: 1,  low: 2, c: 16, mn: 1,  mx: 1,  ovf: 0};
      tbl[5] = '{n: 1,  w: 65, low: 1, c: 1,  mn: 64, mx: 64, ovf: 1};

      #1 rstn = 1'b0;
      #20;
      expect_zero("reset");
      @(posedge clk);
      #1 rstn = 1'b1;
      drive(1'b0, 3);

      foreach (tbl[i]) begin
         burst(tbl[i].n, tbl[i].w, tbl[i].low);
         check($sformatf("tbl%0d.pre_gap", i), int'(rif.res_valid), 0);
         step(1'b0);
         expect_rec($sformatf("tbl%0d", i), tbl[i].c, tbl[i].mn, tbl[i].mx, tbl[i].ovf,
                    werr_exp(int'(tbl[i].w != 4)));
         accept($sformatf("tbl%0d", i));
      end

      drive(1'b1, 2); drive(1'b0, 3); drive(1'b1, 5); drive(1'b0, 3); drive(1'b1, 3);
      drive(1'b0, GAP);
      expect_rec("w253", 3, 2, 5, 0, werr_exp(1));
      accept("w253");

      // Eight lows split the stream into two records.
      burst(1, 2, 0);
      step(1'b0);
      expect_rec("gap8a", 1, 2, 2, 0, werr_exp(1));
      rif.res_ready = 1'b1;
      step(1'b1);
      rif.res_ready = 1'b0;
      check("gap8a.accepted", int'(rif.res_valid), 0);
      drive(1'b1, 2);
      drive(1'b0, GAP);
      expect_rec("gap8b", 1, 3, 3, 0, werr_exp(1));
      accept("gap8b");

      burst(1, 3, 0);
      step(1'b0);
      expect_rec("hold1", 1, 3, 3, 0, werr_exp(1));
      burst(2, 2, 2);
      step(1'b0);
      expect_rec("hold2", 1, 3, 3, 0, werr_exp(1));
      check("hold2.drop", int'(drop_cnt), 1);
      clr = 1'b1;
      step(1'b0);
      clr = 1'b0;
      expect_zero("clr_idle");

      burst(1, 3, 0);
      step(1'b0);
      expect_rec("repl1", 1, 3, 3, 0, werr_exp(1));
      burst(2, 2, 2);
      rif.res_ready = 1'b1;
      step(1'b0);
      rif.res_ready = 1'b0;
      expect_rec("repl2", 2, 2, 2, 0, werr_exp(1));
      check("repl2.drop", int'(drop_cnt), 0);
      accept("repl2");

      burst(1, 5, 0);
      step(1'b0);
      drive(1'b1, 3);
      rstn = 1'b0;
      pulse_in = 1'b0;
      #2;
      expect_zero("rst_mid");
      @(posedge clk);
      #1 rstn = 1'b1;
      burst(1, 4, 0);
      step(1'b0);
      expect_rec("post_rst", 1, 4, 4, 0, 0);
      accept("post_rst");

      burst(1, 6, 0);
      step(1'b0);
      drive(1'b1, 1);
      drive(1'b0, GAP);
      check("pre_clr.drop", int'(drop_cnt), 1);
      drive(1'b1, 3); drive(1'b0, 2); drive(1'b1, 2);
      clr = 1'b1;
      step(1'b0);
      clr = 1'b0;
      expect_zero("clr_mid");
      burst(1, 2, 0);
      step(1'b0);
      expect_rec("post_clr", 1, 2, 2, 0, werr_exp(1));
      accept("post_clr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
